// File: rtl/fetch_entry_queue.sv
// rtl/fetch_entry_queue.sv - decoupling FIFO of fetch entries between frontend and decode.
// Output is registered-only: an entry is never forwarded combinationally from the input.
module fetch_entry_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ENTRY_W = 103
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic [ENTRY_W-1:0]         fetch_entry_i,
  input  logic                       fetch_entry_valid_i,
  output logic                       fetch_entry_ready_o,
  output logic [ENTRY_W-1:0]         fetch_entry_o,
  output logic                       fetch_entry_valid_o,
  input  logic                       fetch_ack_i,
  output logic [$clog2(DEPTH):0]     usage_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_entry_queue: DEPTH must be a power of two and at least 2");
  end

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push, pop;

  assign fetch_entry_ready_o = (count_q != FULL_CNT);
  assign fetch_entry_valid_o = (count_q != '0);
  assign fetch_entry_o       = mem_q[rd_ptr_q];
  assign usage_o             = count_q;

  // Ready is purely registered, so a full queue never accepts even when decode acks.
  assign push = fetch_entry_valid_i && fetch_entry_ready_o && !flush_i;
  assign pop  = fetch_ack_i && fetch_entry_valid_o && !flush_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left unreset; its contents are don't-care while the count is zero.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= fetch_entry_i;
  end

endmodule

// File: tb/tb_fetch_entry_queue.sv
// tb/tb_fetch_entry_queue.sv - table-driven scoreboard bench for fetch_entry_queue.
module tb_fetch_entry_queue;

  localparam int DEPTH   = 4;
  localparam int ENTRY_W = 103;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] instruction;
    logic        bp_valid;
    logic        bp_taken;
    logic [31:0] bp_target;
    logic        ex_valid;
    logic [3:0]  ex_cause;
  } fetch_entry_t;

  typedef struct {
    bit          flush;
    bit          valid;
    bit          ack;
    logic [31:0] addr;
    int          exp_usage;
    bit          exp_valid;
    bit          exp_ready;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  logic [ENTRY_W-1:0] entry_in;
  logic               entry_valid_in;
  logic               entry_ready;
  logic [ENTRY_W-1:0] entry_out;
  logic               entry_valid_out;
  logic               ack;
  logic [2:0]         usage;

  int checks = 0;
  int errors = 0;

  fetch_entry_t sb[$];
  int           mcount = 0;
  vec_t         tbl[$];

  always #5 clk = ~clk;

  fetch_entry_queue #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .flush_i            (flush),
    .fetch_entry_i      (entry_in),
    .fetch_entry_valid_i(entry_valid_in),
    .fetch_entry_ready_o(entry_ready),
    .fetch_entry_o      (entry_out),
    .fetch_entry_valid_o(entry_valid_out),
    .fetch_ack_i        (ack),
    .usage_o            (usage)
  );

  function automatic fetch_entry_t make_entry(input logic [31:0] addr);
    fetch_entry_t e;
    e.address     = addr;
    e.instruction = addr ^ 32'h0000_0013;
    e.bp_valid    = 1'b1;
    e.bp_taken    = addr[2];
    e.bp_target   = addr + 32'h40;
    e.ex_valid    = addr[3];
    e.ex_cause    = addr[7:4];
    return e;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input bit f, input bit v, input bit a, input logic [31:0] addr,
                              input int eu, input bit ev, input bit er);
    vec_t t;
    t.flush = f; t.valid = v; t.ack = a; t.addr = addr;
    t.exp_usage = eu; t.exp_valid = ev; t.exp_ready = er;
    tbl.push_back(t);
  endfunction

  // Drive one cycle, update the bench model, then sample after the edge.
  task automatic step(input vec_t t);
    bit m_ready, m_valid;
    fetch_entry_t e;
    e = make_entry(t.addr);
    flush = t.flush; entry_valid_in = t.valid; ack = t.ack; entry_in = e;
    m_ready = (mcount != DEPTH);
    m_valid = (mcount != 0);
    if (t.flush) begin
      sb.delete();
      mcount = 0;
    end else begin
      if (t.ack && m_valid) begin
        check("pop_data", entry_out, sb[0]);
        void'(sb.pop_front());
        mcount--;
      end
      if (t.valid && m_ready) begin
        sb.push_back(e);
        mcount++;
      end
    end
    @(posedge clk);
    #1;
    check("usage", usage, t.exp_usage);
    check("usage_model", usage, mcount);
    check("valid", entry_valid_out, t.exp_valid);
    check("ready", entry_ready, t.exp_ready);
    if (mcount != 0) check("head", entry_out, sb[0]);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; entry_valid_in = 1'b0; ack = 1'b0; entry_in = '0;

    // Fill A0..A3, full+ack with A4, then drain to count 1.
    for (int i = 0; i < 4; i++) add(0, 1, 0, 32'h8000_0000 + 32'(4 * i), i + 1, 1, i != 3);
    add(0, 1, 1, 32'h8000_0010, 3, 1, 1);
    add(0, 1, 0, 32'h8000_0010, 4, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 32'h0, 3 - i, 1, 1);
    // Streaming at count 1 across pointer wrap.
    for (int i = 0; i < 16; i++) add(0, 1, 1, 32'h8000_0100 + 32'(4 * i), 1, 1, 1);
    // Reach count 3, then flush with valid and ack asserted.
    add(0, 1, 0, 32'h8000_0200, 2, 1, 1);
    add(0, 1, 0, 32'h8000_0204, 3, 1, 1);
    add(1, 1, 1, 32'hDEAD_BEE0, 0, 0, 1);
    // Spurious ack while empty, then a push becomes head one cycle later.
    for (int i = 0; i < 3; i++) add(0, 0, 1, 32'h0, 0, 0, 1);
    add(0, 1, 0, 32'h8000_1000, 1, 1, 1);
    add(0, 0, 1, 32'h0, 0, 0, 1);
    // Push right after the flush recovery.
    add(0, 1, 0, 32'h8000_2000, 1, 1, 1);
    add(0, 1, 0, 32'h8000_2004, 2, 1, 1);

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", entry_valid_out, 1'b0);
    check("rst_ready", entry_ready, 1'b1);
    check("rst_usage", usage, 3'd0);
    rst = 1'b0;

    foreach (tbl[i]) step(tbl[i]);

    // Flush at edge N, push in cycle N+1 accepted.
    begin
      vec_t t;
      t.flush = 1; t.valid = 0; t.ack = 0; t.addr = 0; t.exp_usage = 0; t.exp_valid = 0; t.exp_ready = 1;
      step(t);
      t.flush = 0; t.valid = 1; t.addr = 32'h8000_3000; t.exp_usage = 1; t.exp_valid = 1;
      step(t);
      t.addr = 32'h8000_3004; t.exp_usage = 2;
      step(t);
    end

    // Asynchronous reset between edges at count 2.
    flush = 1'b0; entry_valid_in = 1'b0; ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_valid", entry_valid_out, 1'b0);
    check("arst_usage", usage, 3'd0);
    check("arst_ready", entry_ready, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    mcount = 0;
    check("post_rst_usage", usage, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
